// File: rtl/set_host.sv
`default_nettype none
// ============================================================================
// Module   : set_host
// Purpose  : Queues set-engine commands in a 4-deep FIFO, issues them one at a
//            time and scores each engine result against the expected count.
//            Optional watchdog: define SET_HOST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module set_host (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_wr,
    input  logic [45:0] cmd_data,
    output logic        cmd_full,
    output logic        en,
    output logic [23:0] central,
    output logic [11:0] radius,
    output logic [1:0]  mode,
    input  logic        busy,
    input  logic        valid,
    input  logic [7:0]  candidate,
    output logic        res_valid,
    output logic [7:0]  res_candidate,
    output logic        res_match,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic [2:0]  status
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [45:0] fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [23:0] central_q, central_d;
    logic [11:0] radius_q, radius_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  exp_q, exp_d;
    logic [7:0]  res_cand_q, res_cand_d;
    logic [7:0]  pass_q, pass_d, fail_q, fail_d;
    logic        ovf_q, ovf_d;
    logic        full, push, pop, match, to_flag;
    logic [45:0] head;

`ifdef SET_HOST_TIMEOUT_EN
    logic [7:0]  wd_q, wd_d;
    logic        to_sticky_q, to_sticky_d;
    logic        timed_out_q, timed_out_d;
`endif

    assign full = (count_q == 3'd4);
    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push = cmd_wr && !full;
    assign pop  = (state_q == S_IDLE) && (count_q != 3'd0);
    assign head = fifo_mem_q[rd_ptr_q];

`ifdef SET_HOST_TIMEOUT_EN
    assign to_flag = to_sticky_q;
    assign match   = !timed_out_q && (res_cand_q == exp_q);
`else
    assign to_flag = 1'b0;
    assign match   = (res_cand_q == exp_q);
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + {1'b0, push};
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        count_d    = count_q + {2'b00, push} - {2'b00, pop};
        central_d  = central_q;
        radius_d   = radius_q;
        mode_d     = mode_q;
        exp_d      = exp_q;
        res_cand_d = res_cand_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ovf_d      = ovf_q | (cmd_wr && full);
        en         = 1'b0;
`ifdef SET_HOST_TIMEOUT_EN
        wd_d        = wd_q;
        to_sticky_d = to_sticky_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    exp_d     = head[45:38];
                    mode_d    = head[37:36];
                    central_d = head[35:12];
                    radius_d  = head[11:0];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!busy) begin
                    en      = 1'b1;
                    state_d = S_WAIT;
`ifdef SET_HOST_TIMEOUT_EN
                    wd_d    = 8'd0;
`endif
                end
            end
            S_WAIT: begin
                if (valid) begin
                    res_cand_d  = candidate;
                    state_d     = S_REPORT;
`ifdef SET_HOST_TIMEOUT_EN
                    timed_out_d = 1'b0;
                end else if (wd_q == 8'd254) begin
                    // 255th idle WAIT cycle: report as a failed, empty result
                    res_cand_d  = 8'd0;
                    timed_out_d = 1'b1;
                    to_sticky_d = 1'b1;
                    state_d     = S_REPORT;
                end else begin
                    wd_d        = wd_q + 8'd1;
`endif
                end
            end
            S_REPORT: begin
                if (match) begin
                    if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
                end else begin
                    if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= cmd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            central_q  <= 24'd0;
            radius_q   <= 12'd0;
            mode_q     <= 2'd0;
            exp_q      <= 8'd0;
            res_cand_q <= 8'd0;
            pass_q     <= 8'd0;
            fail_q     <= 8'd0;
            ovf_q      <= 1'b0;
`ifdef SET_HOST_TIMEOUT_EN
            wd_q        <= 8'd0;
            to_sticky_q <= 1'b0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            central_q  <= central_d;
            radius_q   <= radius_d;
            mode_q     <= mode_d;
            exp_q      <= exp_d;
            res_cand_q <= res_cand_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ovf_q      <= ovf_d;
`ifdef SET_HOST_TIMEOUT_EN
            wd_q        <= wd_d;
            to_sticky_q <= to_sticky_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign cmd_full      = full;
    assign central       = central_q;
    assign radius        = radius_q;
    assign mode          = mode_q;
    assign res_valid     = (state_q == S_REPORT);
    assign res_match     = (state_q == S_REPORT) && match;
    assign res_candidate = res_cand_q;
    assign pass_cnt      = pass_q;
    assign fail_cnt      = fail_q;
    assign status        = {ovf_q, to_flag, (state_q == S_IDLE) && (count_q == 3'd0)};

endmodule
`default_nettype wire

// File: tb/tb_set_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_host
// Purpose  : Self-checking bench for set_host: transaction-level reference
//            model compared every cycle, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_host;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [45:0] cmd_data = '0;
    logic        busy = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  candidate = '0;
    logic        cmd_full, en, res_valid, res_match;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic [7:0]  res_candidate, pass_cnt, fail_cnt;
    logic [2:0]  status;

    set_host dut (
        .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
        .cmd_full(cmd_full), .en(en), .central(central), .radius(radius),
        .mode(mode), .busy(busy), .valid(valid), .candidate(candidate),
        .res_valid(res_valid), .res_candidate(res_candidate),
        .res_match(res_match), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .status(status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: a command queue plus the one command in flight.
    logic [45:0] m_q[$];
    bit          started = 0;
    bit          m_active, m_issued, m_got, m_to, m_ovf, m_tos;
    logic [7:0]  m_exp, m_cand, m_pass, m_fail;
    logic [23:0] m_central;
    logic [11:0] m_radius;
    logic [1:0]  m_mode;
    int          m_wait;
    bit          full0, do_pop;
    logic [45:0] hc;

    // Engine emulation and observation statistics
    int          bmode = 0;   // 0 ready, 1 stalled, 2 random
    int          vmode = 0;   // 0 never, 1 random, 2 answer each en, 3 manual
    bit          eng_req = 0;
    logic [7:0]  eng_cand = '0;
    int          en_count = 0, rv_count = 0, cyc = 0, en_cyc = 0, rv_cyc = 0;
    logic        last_match = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (started) begin
            chk("cmd_full", cmd_full, m_q.size() == 4);
            chk("en", en, m_active && !m_issued && !busy);
            chk("res_valid", res_valid, m_active && m_got);
            chk("res_match", res_match, m_active && m_got && !m_to && (m_cand == m_exp));
            chk("res_candidate", res_candidate, m_cand);
            chk("central", central, m_central);
            chk("radius", radius, m_radius);
            chk("mode", mode, m_mode);
            chk("pass_cnt", pass_cnt, m_pass);
            chk("fail_cnt", fail_cnt, m_fail);
            chk("status", status, {m_ovf, m_tos, !m_active && m_q.size() == 0});
        end
        if (en === 1'b1) begin en_count++; eng_req = 1; en_cyc = cyc; end
        if (res_valid === 1'b1) begin rv_count++; last_match = res_match; rv_cyc = cyc; end

        // Advance the model with the inputs the DUT samples at the next edge.
        if (rst) begin
            m_q.delete();
            started = 1;
            {m_active, m_issued, m_got, m_to, m_ovf, m_tos} = '0;
            m_exp = 0; m_cand = 0; m_pass = 0; m_fail = 0;
            m_central = 0; m_radius = 0; m_mode = 0; m_wait = 0;
        end else if (started) begin
            full0  = (m_q.size() == 4);
            do_pop = !m_active && (m_q.size() > 0);
            if (cmd_wr && full0) m_ovf = 1;
            if (m_active && m_got) begin
                if (!m_to && m_cand == m_exp) begin
                    if (m_pass != 8'hFF) m_pass = m_pass + 8'd1;
                end else begin
                    if (m_fail != 8'hFF) m_fail = m_fail + 8'd1;
                end
                m_active = 0;
            end else if (m_active && m_issued) begin
                if (valid) begin
                    m_cand = candidate; m_to = 0; m_got = 1;
                end else begin
                    m_wait++;
`ifdef SET_HOST_TIMEOUT_EN
                    if (m_wait == 255) begin
                        m_got = 1; m_cand = 0; m_to = 1; m_tos = 1;
                    end
`endif
                end
            end else if (m_active) begin
                if (!busy) begin m_issued = 1; m_wait = 0; end
            end
            if (do_pop) begin
                hc = m_q.pop_front();
                m_exp = hc[45:38]; m_mode = hc[37:36];
                m_central = hc[35:12]; m_radius = hc[11:0];
                m_active = 1; m_issued = 0; m_got = 0;
            end
            if (cmd_wr && !full0) m_q.push_back(cmd_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cmd_wr = 1'b0;
        case (bmode)
            0:       busy = 1'b0;
            1:       busy = 1'b1;
            default: busy = ($urandom_range(0, 3) == 0);
        endcase
        if (vmode == 2) begin
            valid = 1'b0;
            if (eng_req) begin valid = 1'b1; candidate = eng_cand; eng_req = 0; end
        end else if (vmode == 1) begin
            valid = 1'b0;
            if ((eng_req && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0) begin
                valid = 1'b1;
                eng_req = 0;
                candidate = ($urandom_range(0, 1) == 1) ? m_exp : 8'($urandom);
            end
        end else if (vmode == 0) begin
            valid = 1'b0;
        end
    endtask

    task automatic push(input logic [45:0] d);
        cmd_wr   = 1'b1;
        cmd_data = d;
        tick();
    endtask

    task automatic wait_rv(input int n, input string name);
        int base;
        base = rv_count;
        for (int i = 0; i < n && rv_count == base; i++) tick();
        chk(name, rv_count != base, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        eng_req = 0;
    endtask

    initial begin
        int base;
        do_reset();
        chk("reset_status", status, 3'b001);
        chk("reset_counts", {pass_cnt, fail_cnt}, 16'h0000);
        chk("reset_central", central, 24'h0);
        chk("reset_res_cand", res_candidate, 8'h0);

        // Matching result
        en_count = 0; vmode = 2; eng_cand = 8'h15;
        push({8'h15, 2'd0, 24'h440000, 12'h300});
        wait_rv(20, "match_report");
        chk("match_en_once", en_count, 1);
        chk("match_res_match", last_match, 1'b1);
        chk("match_pass_cnt", pass_cnt, 8'd1);
        chk("match_model_pass", m_pass, 8'd1);
        chk("match_central_held", central, 24'h440000);
        chk("match_radius_held", radius, 12'h300);

        // Engine busy for 10 cycles; mode 3 forwarded unchanged
        en_count = 0; bmode = 1; eng_cand = 8'h22;
        push({8'h22, 2'd3, 24'h123456, 12'hABC});
        repeat (10) tick();
        chk("busy_en_held", en_count, 0);
        chk("busy_mode3", mode, 2'd3);
        bmode = 0;
        wait_rv(20, "busy_report");
        chk("busy_en_once", en_count, 1);
        chk("busy_pass_cnt", pass_cnt, 8'd2);

        // Mismatch
        eng_cand = 8'h0F;
        push({8'h10, 2'd1, 24'h000111, 12'h222});
        wait_rv(20, "mismatch_report");
        chk("mismatch_res_match", last_match, 1'b0);
        chk("mismatch_fail_cnt", fail_cnt, 8'd1);
        chk("mismatch_pass_cnt", pass_cnt, 8'd2);

        // Overflow: one command parked in ISSUE, then five pushes
        bmode = 1; eng_cand = 8'h5A;
        base = rv_count;
        push({8'h5A, 2'd2, 24'hABCDEF, 12'h001});
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            push({8'(8'h50 + i), 2'd0, 24'(i), 12'(i)});
            if (i == 2) chk("ovf_not_full_at3", cmd_full, 1'b0);
            if (i == 3) chk("ovf_full_at4", cmd_full, 1'b1);
        end
        chk("ovf_sticky", status[2], 1'b1);
        bmode = 0;
        for (int i = 0; i < 80 && rv_count - base < 5; i++) tick();
        repeat (10) tick();
        chk("ovf_report_count", rv_count - base, 5);

        // Reset during WAIT, then a late engine valid
        do_reset();
        vmode = 0;
        base = rv_count;
        push({8'h33, 2'd0, 24'h000001, 12'h001});
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        vmode = 3; valid = 1'b1; candidate = 8'h33;
        tick(); tick();
        valid = 1'b0; vmode = 0;
        tick();
        chk("rstwait_no_report", rv_count - base, 0);
        chk("rstwait_counts", {pass_cnt, fail_cnt}, 16'h0000);
        chk("rstwait_idle", status, 3'b001);

        // Engine never answers
        do_reset();
        base = rv_count;
        push({8'h00, 2'd0, 24'h000002, 12'h002});
`ifdef SET_HOST_TIMEOUT_EN
        wait_rv(300, "timeout_report");
        chk("timeout_latency", rv_cyc - en_cyc, 256);
        chk("timeout_match", last_match, 1'b0);
        chk("timeout_fail_cnt", fail_cnt, 8'd1);
        chk("timeout_sticky", status[1], 1'b1);
        chk("timeout_res_cand", res_candidate, 8'h00);
`else
        repeat (300) tick();
        chk("nowd_no_report", rv_count - base, 0);
        chk("nowd_status", status, 3'b000);
`endif

        // Randomised traffic with occasional resets
        do_reset();
        vmode = 1; bmode = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end else if ($urandom_range(0, 7) < 3) begin
                push({8'($urandom_range(0, 7)), 2'($urandom), 24'($urandom), 12'($urandom)});
            end else begin
                tick();
            end
        end
        bmode = 0;
        repeat (600) tick();
        chk("drain_idle", status[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
